// File: rtl/mcu_pkg.sv
// mcu_pkg: shared opcodes, ALU encodings, FSM states and instruction field positions for the MCU control sequencer.
package mcu_pkg;
  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_ADDI = 4'h6;
  localparam logic [3:0] OP_LDI  = 4'h7;
  localparam logic [3:0] OP_BEQZ = 4'h8;
  localparam logic [3:0] OP_JMP  = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hF;
  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_AND  = 3'd2;
  localparam logic [2:0] ALU_OR   = 3'd3;
  localparam logic [2:0] ALU_XOR  = 3'd4;
  localparam logic [2:0] ALU_PASS = 3'd5;
  localparam int OP_HI  = 15;
  localparam int OP_LO  = 12;
  localparam int RD_HI  = 11;
  localparam int RD_LO  = 9;
  localparam int RS_HI  = 8;
  localparam int RS_LO  = 6;
  localparam int IMM_HI = 5;
  localparam int IMM_LO = 0;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT} state_t;
  typedef enum logic [1:0] {BR_NONE, BR_BEQZ, BR_JMP} br_t;
endpackage

// File: rtl/mcu_instr_decode.sv
// mcu_instr_decode: combinational opcode decode; branches decode only when MCU_CTRL_BRANCH_EN is defined.
module mcu_instr_decode
  import mcu_pkg::*;
(
  input  logic [3:0] i_opcode,
  output logic       o_cs,
  output logic [2:0] o_alu_op,
  output logic       o_alu_src_imm,
  output logic       o_reg_we,
  output br_t        o_br,
  output logic       o_halt,
  output logic       o_illegal
);
  always_comb begin
    o_cs = 1'b0;
    o_alu_op = ALU_ADD;
    o_alu_src_imm = 1'b0;
    o_reg_we = 1'b0;
    o_br = BR_NONE;
    o_halt = 1'b0;
    o_illegal = 1'b0;
    case (i_opcode)
      OP_NOP: ;
      OP_ADD: o_reg_we = 1'b1;
      OP_SUB: begin o_reg_we = 1'b1; o_alu_op = ALU_SUB; end
      OP_AND: begin o_reg_we = 1'b1; o_alu_op = ALU_AND; end
      OP_OR:  begin o_reg_we = 1'b1; o_alu_op = ALU_OR; end
      OP_XOR: begin o_reg_we = 1'b1; o_alu_op = ALU_XOR; end
      OP_ADDI: begin o_reg_we = 1'b1; o_cs = 1'b1; o_alu_src_imm = 1'b1; end
      OP_LDI: begin o_reg_we = 1'b1; o_alu_op = ALU_PASS; o_alu_src_imm = 1'b1; end
`ifdef MCU_CTRL_BRANCH_EN
      OP_BEQZ: begin o_cs = 1'b1; o_br = BR_BEQZ; end
      OP_JMP:  begin o_cs = 1'b1; o_br = BR_JMP; end
`endif
      OP_HALT: o_halt = 1'b1;
      default: o_illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/mcu_ctrl_seq.sv
// mcu_ctrl_seq: fetch/decode/exec/writeback sequencer owning the PC; MCU_CTRL_BRANCH_EN enables BEQZ/JMP and the PC-relative adder.
module mcu_ctrl_seq
  import mcu_pkg::*;
#(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  output logic        imem_req,
  output logic [7:0]  imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic [5:0]  imm,
  output logic        cs,
  input  logic [7:0]  const_val,
  input  logic        zero_flag,
  output logic [2:0]  alu_op,
  output logic        alu_src_imm,
  output logic [2:0]  rd_addr,
  output logic [2:0]  rs_addr,
  output logic        reg_we,
  output logic        busy,
  output logic        halted,
  output logic        illegal
);
  state_t r_state, w_next;
  logic [7:0] r_pc, w_pc_next;
  logic [15:0] r_ir;
  logic w_cs, w_src, w_we, w_halt, w_ill, w_dec, w_alu;
  logic [2:0] w_op;
  br_t w_br;
  mcu_instr_decode u_dec (
    .i_opcode(r_ir[OP_HI:OP_LO]),
    .o_cs(w_cs),
    .o_alu_op(w_op),
    .o_alu_src_imm(w_src),
    .o_reg_we(w_we),
    .o_br(w_br),
    .o_halt(w_halt),
    .o_illegal(w_ill)
  );
`ifdef MCU_CTRL_BRANCH_EN
  logic r_taken;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_taken <= 1'b0;
    else if (r_state == S_EXEC) r_taken <= (w_br == BR_JMP) || (w_br == BR_BEQZ && zero_flag);
  assign w_pc_next = r_pc + (r_taken ? const_val : 8'd1);
`else
  logic w_unused;
  assign w_unused = ^{const_val, zero_flag, w_br};
  assign w_pc_next = r_pc + 8'd1;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_pc <= RESET_PC;
      r_ir <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_FETCH && imem_ack) r_ir <= imem_rdata;
      if (r_state == S_WB && !w_halt) r_pc <= w_pc_next;
    end
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   w_next = run ? S_FETCH : S_IDLE;
      S_FETCH:  w_next = imem_ack ? S_DECODE : S_FETCH;
      S_DECODE: w_next = S_EXEC;
      S_EXEC:   w_next = S_WB;
      S_WB:     w_next = w_halt ? S_HALT : (run ? S_FETCH : S_IDLE);
      default:  w_next = r_state;
    endcase
  end
  // Decoded fields are held from DECODE through WB so const_val settles before WB uses it.
  assign w_dec = r_state inside {S_DECODE, S_EXEC, S_WB};
  assign w_alu = r_state inside {S_EXEC, S_WB};
  assign imem_req = r_state == S_FETCH;
  assign imem_addr = imem_req ? r_pc : 8'h00;
  assign imm = w_dec ? r_ir[IMM_HI:IMM_LO] : 6'h00;
  assign cs = w_dec & w_cs;
  assign rd_addr = w_dec ? r_ir[RD_HI:RD_LO] : 3'd0;
  assign rs_addr = w_dec ? r_ir[RS_HI:RS_LO] : 3'd0;
  assign alu_op = w_alu ? w_op : ALU_ADD;
  assign alu_src_imm = w_alu & w_src;
  assign reg_we = r_state == S_WB && w_we;
  assign illegal = r_state == S_DECODE && w_ill;
  assign busy = !(r_state inside {S_IDLE, S_HALT});
  assign halted = r_state == S_HALT;
endmodule

// File: tb/tb_mcu_ctrl_seq.sv
// tb_mcu_ctrl_seq: directed plus randomized instruction stream checked against an instruction-level reference model.
module tb_mcu_ctrl_seq;
  logic clk = 1'b0, rst_n = 1'b1, run = 1'b0;
  logic imem_req, imem_ack = 1'b0;
  logic [7:0] imem_addr, const_val;
  logic [15:0] imem_rdata = '0;
  logic [5:0] imm;
  logic cs, zero_flag = 1'b0, alu_src_imm, reg_we, busy, halted, illegal;
  logic [2:0] alu_op, rd_addr, rs_addr;
  int vectors = 0, miscompares = 0, m_pc = 0;
  typedef struct {
    logic ill, cs, src, we, halt;
    logic [2:0] op;
    int npc;
  } exp_t;
  mcu_ctrl_seq dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .imm(imm), .cs(cs), .const_val(const_val), .zero_flag(zero_flag),
    .alu_op(alu_op), .alu_src_imm(alu_src_imm), .rd_addr(rd_addr), .rs_addr(rs_addr),
    .reg_we(reg_we), .busy(busy), .halted(halted), .illegal(illegal)
  );
  assign const_val = cs ? {{2{imm[5]}}, imm} : {2'b00, imm};
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask
  function automatic exp_t model(input logic [15:0] ir, input int pc, input logic zf);
    exp_t e;
    int opc, iv, off;
    bit br_en, is_br, taken;
    opc = int'(ir[15:12]);
    iv = int'(ir[5:0]);
    off = iv >= 32 ? iv - 64 : iv;
`ifdef MCU_CTRL_BRANCH_EN
    br_en = 1'b1;
`else
    br_en = 1'b0;
`endif
    is_br = br_en && (opc == 8 || opc == 9);
    e.ill = !(opc <= 7 || opc == 15 || is_br);
    e.we = opc >= 1 && opc <= 7;
    e.cs = opc == 6 || is_br;
    e.src = opc == 6 || opc == 7;
    e.op = (opc >= 1 && opc <= 5) ? 3'(opc - 1) : (opc == 7 ? 3'd5 : 3'd0);
    e.halt = opc == 15;
    taken = is_br && (opc == 9 || zf);
    e.npc = (pc + (taken ? off : 1) + 256) % 256;
    return e;
  endfunction
  // Entered at a negedge with the DUT in FETCH; leaves at a negedge in FETCH, IDLE->FETCH, or HALT.
  task automatic do_instr(input logic [15:0] ir, input logic zf, input int waits, input bit drop);
    exp_t e;
    e = model(ir, m_pc, zf);
    zero_flag = zf;
    imem_rdata = ir;
    for (int k = 0; k <= waits; k++) begin
      chk("fetch_req", imem_req, 1);
      chk("fetch_addr", imem_addr, 16'(m_pc));
      imem_ack = (k == waits);
      @(negedge clk);
    end
    imem_ack = 1'b0;
    imem_rdata = 16'($urandom);
    chk("dec_req", imem_req, 0);
    chk("dec_imm", imm, ir[5:0]);
    chk("dec_cs", cs, e.cs);
    chk("dec_rd", rd_addr, ir[11:9]);
    chk("dec_rs", rs_addr, ir[8:6]);
    chk("dec_illegal", illegal, e.ill);
    chk("dec_we", reg_we, 0);
    @(negedge clk);
    chk("exe_op", alu_op, e.op);
    chk("exe_src", alu_src_imm, e.src);
    chk("exe_imm", imm, ir[5:0]);
    chk("exe_illegal", illegal, 0);
    chk("exe_we", reg_we, 0);
    if (drop) run = 1'b0;
    @(negedge clk);
    chk("wb_we", reg_we, e.we);
    chk("wb_op", alu_op, e.op);
    chk("wb_rd", rd_addr, ir[11:9]);
    chk("wb_busy", busy, 1);
    if (!e.halt) m_pc = e.npc;
    @(negedge clk);
    if (e.halt) begin
      chk("halt_halted", halted, 1);
      chk("halt_busy", busy, 0);
    end else if (!run) begin
      chk("idle_busy", busy, 0);
      chk("idle_req", imem_req, 0);
      run = 1'b1;
      @(negedge clk);
    end
  endtask
  task automatic nops(input int n);
    for (int i = 0; i < n; i++) do_instr(16'h0000, 1'b0, 0, 1'b0);
  endtask
  initial begin
    #3 rst_n = 1'b0;
    @(negedge clk);
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_imm", imm, 0);
    chk("rst_cs", cs, 0);
    chk("rst_op", alu_op, 0);
    chk("rst_src", alu_src_imm, 0);
    chk("rst_rd", rd_addr, 0);
    chk("rst_rs", rs_addr, 0);
    chk("rst_we", reg_we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_halted", halted, 0);
    chk("rst_illegal", illegal, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_hold", busy, 0);
    run = 1'b1;
    @(negedge clk);
    do_instr(16'h7205, 1'b1, 0, 1'b0);
    do_instr({4'h6, 3'd2, 3'd3, 6'h3E}, 1'b0, 3, 1'b0);
    nops(16'h10 - m_pc);
    do_instr({4'h8, 3'd0, 3'd0, 6'h3C}, 1'b1, 0, 1'b0);
    nops(16'h10 - m_pc);
    do_instr({4'h8, 3'd0, 3'd0, 6'h3C}, 1'b0, 1, 1'b0);
    nops(16'hFE - m_pc);
    do_instr({4'h9, 3'd0, 3'd0, 6'h04}, 1'b0, 0, 1'b0);
    do_instr({4'h1, 3'd4, 3'd5, 6'h00}, 1'b0, 0, 1'b1);
    for (int i = 0; i < 150; i++)
      do_instr({4'($urandom_range(0, 14)), 12'($urandom)}, 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 7) == 0);
    do_instr(16'hF000, 1'b0, 0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      run = ~run;
      @(negedge clk);
      chk("halt_stay", halted, 1);
      chk("halt_noreq", imem_req, 0);
    end
    #2 rst_n = 1'b0;
    #1 chk("rst_unhalt", halted, 0);
    chk("rst_idle_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run = 1'b1;
    @(negedge clk);
    chk("refetch_req", imem_req, 1);
    chk("refetch_pc", imem_addr, 0);
    @(negedge clk);
    chk("fetch_wait_req", imem_req, 1);
    #2 rst_n = 1'b0;
    #1 chk("async_req_drop", imem_req, 0);
    chk("async_busy", busy, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mcu_ctrl_seq.md
# mcu_ctrl_seq

Multi-cycle control sequencer for the 8-bit MCU datapath. Fetches 16-bit instructions over a request/acknowledge port, decodes them, and drives the constant unit's immediate and sign-select inputs, the ALU and the register-file write strobe. Owns the 8-bit program counter and resolves PC-relative branches using the constant unit's extended output. Sits between instruction memory and the datapath (constant unit, ALU, register file).

## Interface
Parameters:
- RESET_PC, 8'h00: PC value loaded at reset.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- run  in  1  level; 1 = execute instructions, 0 = stop at the next instruction boundary.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  8  fetch address (the current PC).
- imem_ack  in  1  fetch data valid; may assert in the same cycle as imem_req.
- imem_rdata  in  16  instruction word. Fields: [15:12] opcode, [11:9] rd, [8:6] rs, [5:0] imm.
- imm  out  6  immediate to the constant unit.
- cs  out  1  constant-unit sign select; 1 = sign-extend, 0 = zero-extend.
- const_val  in  8  extended constant returned by the constant unit.
- zero_flag  in  1  datapath zero flag.
- alu_op  out  3  ALU operation: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 PASS_B.
- alu_src_imm  out  1  ALU operand B select; 1 = constant, 0 = register rs.
- rd_addr  out  3  destination register.
- rs_addr  out  3  source register.
- reg_we  out  1  register write strobe, one cycle.
- busy  out  1  high when the FSM is not in IDLE or HALT.
- halted  out  1  high in HALT.
- illegal  out  1  one-cycle pulse when an undefined opcode is decoded.

## Operation
- Opcodes:
  - 0 NOP
  - 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR: rd = rd op rs.
  - 6 ADDI: rd = rd + signed imm (cs=1).
  - 7 LDI: rd = unsigned imm (cs=0, PASS_B).
  - 8 BEQZ: branch if zero_flag.
  - 9 JMP: unconditional branch.
  - F HALT.
  - All other opcodes: illegal.
- FSM states: IDLE, FETCH, DECODE, EXEC, WB, HALT.
- IDLE → FETCH when run=1.
- FETCH: imem_req=1 and imem_addr=PC, held until imem_ack. On the ack edge, IR ← imem_rdata, then go to DECODE.
- DECODE: drive imm, cs, rs_addr and rd_addr from IR. These stay stable through EXEC and WB.
  - cs=1 for ADDI, BEQZ and JMP; cs=0 otherwise.
  - Illegal opcode: pulse illegal for one cycle; the instruction then executes as a NOP.
- EXEC: drive alu_op and alu_src_imm. Branch condition is sampled here: taken = JMP, or BEQZ with zero_flag=1.
- WB:
  - reg_we=1 for opcodes 1–7 only.
  - Next PC: PC+1, or PC+const_val if the branch is taken. Both are modulo 256 and relative to the branching instruction's own address.
  - Next state: FETCH if run=1, otherwise IDLE.
- HALT opcode: WB goes to HALT. In HALT, halted=1 and the PC is frozen. HALT is left only through reset.
- run=0 mid-instruction: the current instruction completes, including writeback, and the FSM then goes to IDLE.
- Reset values: state IDLE, PC=RESET_PC, IR=0, every output 0. Reset is asynchronous, so imem_req drops immediately even mid-fetch.

## Timing
- Minimum 4 cycles per instruction (FETCH with same-cycle ack, DECODE, EXEC, WB). Each wait cycle on imem_ack adds one cycle.
- imem_req stays high continuously until ack. imem_addr must not change while imem_req=1.
- const_val is combinational from imm/cs and is valid from DECODE+1 onward. The controller uses it in WB only.
- The new PC is visible on imem_addr in the first FETCH cycle after WB.
- PC wrap: 8'hFF + 1 = 8'h00. Branch offset 6'h3F (−1) from PC 8'h00 gives 8'hFF.

## Configuration
- MCU_CTRL_BRANCH_EN:
  - Defined: opcodes 8 and 9 execute as specified.
  - Undefined: opcodes 8 and 9 are treated as illegal (illegal pulse, executed as NOP), and no PC adder for const_val is synthesized.

## Structure
- Package mcu_pkg holds:
  - opcode localparams
  - alu_op encodings
  - the FSM state enum
  - instruction field bit positions
- One combinational sub-module, mcu_instr_decode, maps IR to cs, alu_op, alu_src_imm, reg write-enable class, branch type and illegal. The FSM and PC stay in mcu_ctrl_seq.

## Test plan
- Reset, run=1, ack in same cycle: IR=16'h7205 (LDI r1,5) → cs=0, imm=5, reg_we pulses in cycle 4, rd_addr=1, next imem_addr=1.
- ADDI with imm=6'h3E → cs=1, alu_op=ADD, alu_src_imm=1. Inserting 3 wait cycles on ack gives a 7-cycle instruction, with imem_req/imem_addr stable throughout.
- BEQZ at PC 8'h10, imm=6'h3C, const_val=8'hFC:
  - zero_flag=1 → next PC 8'h0C.
  - zero_flag=0 → next PC 8'h11.
  - reg_we never asserts.
- JMP at PC 8'hFE with offset +4 → next PC 8'h02 (wrap). With MCU_CTRL_BRANCH_EN undefined → illegal pulse and next PC 8'hFF.
- Opcode F → halted=1 and busy=0. Later run toggles are ignored; rst_n low returns PC=RESET_PC in IDLE.
- run dropped during EXEC of ADD → WB still writes, state goes to IDLE. rst_n asserted mid-FETCH → imem_req=0 immediately.
